// File: rtl/rf_pkg.sv
// Shared register-file writeback types, widths and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    // Writes to x0 are architecturally discarded.
    localparam logic [DEFAULT_ADDRESS_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                              valid;
        logic [DEFAULT_ADDRESS_WIDTH-1:0]  rd;
        logic [DEFAULT_DATA_WIDTH-1:0]     data;
    } wb_req_t;

    typedef enum logic {
        NORMAL = 1'b0,
        BOOST  = 1'b1
    } arb_state_e;

    // Width needed to count up to limit, never narrower than one bit.
    function automatic int starve_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rf_starve_counter.sv
// Counts stalled cycles of a pending memory write and raises priority boost.
// Latency: boost updates one cycle after the stall/accept that causes it.
// Backpressure: none; observes the memory handshake only.
module rf_starve_counter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_valid,
    input  logic mem_req,
    input  logic mem_accept,
    output logic boost
);

    localparam int CW = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          boost_q, boost_d;

    // Next state: count stalls in NORMAL, leave BOOST once memory is served or gone.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            NORMAL: begin
                if (!mem_valid || mem_accept) begin
                    cnt_d = '0;
                end else if (mem_req) begin
                    if (cnt_q < LIMIT_C) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d >= LIMIT_C) begin
                        state_d = BOOST;
                    end
                end
            end
            BOOST: begin
                if (!mem_valid || mem_accept) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = '0;
            end
        endcase
        // A zero limit means memory always holds priority.
        if (STARVE_LIMIT == 0) begin
            state_d = BOOST;
            cnt_d   = '0;
        end
        boost_d = (state_d == BOOST);
    end

    // FSM state, counter and registered boost output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            boost_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boost_q <= boost_d;
        end
    end

    assign boost = boost_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and memory writeback.
// Latency: one cycle from accepted request to WE3/ad3/WD3.
// Backpressure: combinational ready; ALU wins unless memory is starved; x0 always accepted.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     mem_ready,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] ad3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic                     mem_boost
);

    logic alu_x0, mem_x0;
    logic alu_req, mem_req;
    logic alu_win, mem_win;
    logic boost, mem_pri;

    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

    assign alu_x0  = (alu_rd == ADDRESS_WIDTH'(REG_ZERO));
    assign mem_x0  = (mem_rd == ADDRESS_WIDTH'(REG_ZERO));
    assign alu_req = alu_valid && !alu_x0;
    assign mem_req = mem_valid && !mem_x0;
    assign mem_pri = boost || (STARVE_LIMIT == 0);

    rf_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_req    (mem_req),
        .mem_accept (mem_win),
        .boost      (boost)
    );

    // Ready: x0 requests are swallowed at once; otherwise the non-priority side yields.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!rst) begin
            alu_ready = alu_x0 || !(mem_pri && mem_req);
            mem_ready = mem_x0 || !(!mem_pri && alu_req);
        end
    end

    assign alu_win = alu_req && alu_ready;
    assign mem_win = mem_req && mem_ready;

    // Output stage next values: load the single winner, otherwise hold address/data.
    always_comb begin
        we_d  = alu_win || mem_win;
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        if (mem_win) begin
            ad3_d = mem_rd;
            wd3_d = mem_data;
        end else if (alu_win) begin
            ad3_d = alu_rd;
            wd3_d = alu_data;
        end
    end

    // Registered write port; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q  <= 1'b0;
            ad3_q <= '0;
            wd3_q <= '0;
        end else begin
            we_q  <= we_d;
            ad3_q <= ad3_d;
            wd3_q <= wd3_d;
        end
    end

    assign WE3       = we_q;
    assign ad3       = ad3_q;
    assign WD3       = wd3_q;
    assign mem_boost = boost;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int LIMIT = 3;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        WE3;
    logic [4:0]  ad3;
    logic [31:0] WD3;
    logic        mem_boost;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tb_rf [32];

    rf_write_arbiter #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .WE3       (WE3),
        .ad3       (ad3),
        .WD3       (WD3),
        .mem_boost (mem_boost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side register file fed by the write port.
    always @(posedge clk) begin
        if (WE3) tb_rf[ad3] <= WD3;
    end

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 5'd4, 32'hA, 1'b1, 5'd6, 32'hB);
        repeat (2) @(negedge clk);
        n_checks++; if (WE3 !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", WE3); end
        n_checks++; if (ad3 !== 5'd0) begin n_fail++; $display("FAIL reset_ad3: got %0d want 0", ad3); end
        n_checks++; if (WD3 !== 32'd0) begin n_fail++; $display("FAIL reset_wd3: got %0h want 0", WD3); end
        n_checks++; if (mem_boost !== 1'b0) begin n_fail++; $display("FAIL reset_boost: got %0b want 0", mem_boost); end
        n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready: got %0b want 0", alu_ready); end
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready: got %0b want 0", mem_ready); end
        drive(1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hB);
        #1;
        n_checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_x0_ready: got %0b%0b want 00", alu_ready, mem_ready);
        end
        rst = 1'b0;
        drive(1'b1, 5'd4, 32'hA, 1'b1, 5'd6, 32'hB);
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL release_ready: got %0b%0b want 10", alu_ready, mem_ready);
        end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'd4 || WD3 !== 32'hA) begin
            n_fail++; $display("FAIL release_write: got %0b/%0d/%0h want 1/4/a", WE3, ad3, WD3);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b0 || mem_boost !== 1'b0) begin
            n_fail++; $display("FAIL release_idle: got we=%0b boost=%0b want 0/0", WE3, mem_boost);
        end
    endtask

    task automatic test_single_alu;
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b want 1", alu_ready); end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_write: got %0b/%0d/%0h want 1/5/deadbeef", WE3, ad3, WD3);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b0 || ad3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_hold: got %0b/%0d/%0h want 0/5/deadbeef", WE3, ad3, WD3);
        end
    endtask

    task automatic test_contention;
        int exp_seq [7] = '{1, 2, 3, 7, 4, 5, 6};
        int ai = 1;
        bit mdone = 1'b0;
        logic [31:0] exp_wd;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                exp_wd = (exp_seq[c-1] == 7) ? 32'h55 : 32'h100 + 32'(exp_seq[c-1]);
                n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'(exp_seq[c-1]) || WD3 !== exp_wd) begin
                    n_fail++; $display("FAIL contention_write[%0d]: got %0b/%0d/%0h want 1/%0d/%0h",
                                       c, WE3, ad3, WD3, exp_seq[c-1], exp_wd);
                end
            end
            n_checks++; if (mem_boost !== (c == 3)) begin
                n_fail++; $display("FAIL contention_boost[%0d]: got %0b want %0b", c, mem_boost, (c == 3));
            end
            if (c < 7) begin
                drive(ai <= 6, 5'(ai), 32'h100 + 32'(ai), !mdone, 5'd7, 32'h55);
                #1;
                n_checks++; if (alu_ready !== (c != 3)) begin
                    n_fail++; $display("FAIL contention_alu_ready[%0d]: got %0b want %0b", c, alu_ready, (c != 3));
                end
                if (c <= 3) begin
                    n_checks++; if (mem_ready !== (c == 3)) begin
                        n_fail++; $display("FAIL contention_mem_ready[%0d]: got %0b want %0b", c, mem_ready, (c == 3));
                    end
                end
                if (c == 3) mdone = 1'b1;
                else        ai++;
            end else begin
                drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            end
            @(negedge clk);
        end
        n_checks++; if (WE3 !== 1'b0 || mem_boost !== 1'b0) begin
            n_fail++; $display("FAIL contention_end: got we=%0b boost=%0b want 0/0", WE3, mem_boost);
        end
    endtask

    task automatic test_x0;
        @(negedge clk);
        drive(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_both_ready: got %0b%0b want 11", alu_ready, mem_ready);
        end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b0 || mem_boost !== 1'b0) begin
            n_fail++; $display("FAIL x0_no_write: got we=%0b boost=%0b want 0/0", WE3, mem_boost);
        end
        drive(1'b1, 5'd0, 32'h33, 1'b1, 5'd9, 32'h99);
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_mixed_ready: got %0b%0b want 11", alu_ready, mem_ready);
        end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'd9 || WD3 !== 32'h99) begin
            n_fail++; $display("FAIL x0_mixed_write: got %0b/%0d/%0h want 1/9/99", WE3, ad3, WD3);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b0) begin n_fail++; $display("FAIL x0_after: got %0b want 0", WE3); end
    endtask

    task automatic test_same_rd;
        @(negedge clk);
        drive(1'b1, 5'd8, 32'h1, 1'b1, 5'd8, 32'h2);
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL same_rd_ready1: got %0b%0b want 10", alu_ready, mem_ready);
        end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'd8 || WD3 !== 32'h1) begin
            n_fail++; $display("FAIL same_rd_first: got %0b/%0d/%0h want 1/8/1", WE3, ad3, WD3);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h2);
        #1;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL same_rd_ready2: got %0b want 1", mem_ready); end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'd8 || WD3 !== 32'h2) begin
            n_fail++; $display("FAIL same_rd_second: got %0b/%0d/%0h want 1/8/2", WE3, ad3, WD3);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (tb_rf[8] !== 32'h2) begin n_fail++; $display("FAIL same_rd_final: got %0h want 2", tb_rf[8]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hA0);
        #1;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %0b want 0", mem_ready); end
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0);
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'd3 || WD3 !== 32'h33) begin
            n_fail++; $display("FAIL rmid_write: got %0b/%0d/%0h want 1/3/33", WE3, ad3, WD3);
        end
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0);
        #1;
        n_checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ready: got %0b%0b want 00", alu_ready, mem_ready);
        end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b0 || ad3 !== 5'd0 || WD3 !== 32'd0 || mem_boost !== 1'b0) begin
            n_fail++; $display("FAIL rmid_dropped: got %0b/%0d/%0h boost=%0b want 0/0/0 boost=0", WE3, ad3, WD3, mem_boost);
        end
        rst = 1'b0;
        // Counter must restart from zero: boost only after three fresh stalls.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(11 + k), 32'h200 + 32'(k), 1'b1, 5'd10, 32'hA0);
            @(negedge clk);
            n_checks++; if (mem_boost !== (k == 2)) begin
                n_fail++; $display("FAIL rmid_boost[%0d]: got %0b want %0b", k, mem_boost, (k == 2));
            end
        end
        drive(1'b1, 5'd14, 32'h203, 1'b1, 5'd10, 32'hA0);
        #1;
        n_checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_boost_ready: got alu=%0b mem=%0b want 0/1", alu_ready, mem_ready);
        end
        @(negedge clk);
        n_checks++; if (WE3 !== 1'b1 || ad3 !== 5'd10 || WD3 !== 32'hA0) begin
            n_fail++; $display("FAIL rmid_mem_write: got %0b/%0d/%0h want 1/10/a0", WE3, ad3, WD3);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (mem_boost !== 1'b0) begin n_fail++; $display("FAIL rmid_unboost: got %0b want 0", mem_boost); end
    endtask

    // Random traffic against a transaction-level model of the arbitration rules.
    task automatic test_random;
        wb_req_t a, m;
        bit          m_boost = 1'b0;
        int          m_starve = 0;
        bit          exp_we = 1'b0;
        logic [4:0]  exp_ad = 5'd0;
        logic [31:0] exp_wd = 32'd0;
        bit a_req, m_req, mem_wins, alu_wins, exp_ar, exp_mr;
        a = '0;
        m = '0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            n_checks++; if (WE3 !== exp_we || ad3 !== exp_ad || WD3 !== exp_wd || mem_boost !== m_boost) begin
                n_fail++; $display("FAIL rand_out[%0d]: got %0b/%0d/%0h boost=%0b want %0b/%0d/%0h boost=%0b",
                                   c, WE3, ad3, WD3, mem_boost, exp_we, exp_ad, exp_wd, m_boost);
            end
            if (!a.valid && $urandom_range(0, 3) != 0) begin
                a.valid = 1'b1;
                a.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                a.data  = $urandom;
            end
            if (m.valid && m.rd != 5'd0 && $urandom_range(0, 29) == 0) begin
                m.valid = 1'b0;
            end else if (!m.valid && $urandom_range(0, 2) != 0) begin
                m.valid = 1'b1;
                m.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                m.data  = $urandom;
            end
            drive(a.valid, a.rd, a.data, m.valid, m.rd, m.data);
            #1;
            a_req    = a.valid && (a.rd != 5'd0);
            m_req    = m.valid && (m.rd != 5'd0);
            mem_wins = m_req && (m_boost || !a_req);
            alu_wins = a_req && !mem_wins;
            exp_ar   = (a.rd == 5'd0) || alu_wins;
            exp_mr   = (m.rd == 5'd0) || mem_wins;
            if (a.valid) begin
                n_checks++; if (alu_ready !== exp_ar) begin
                    n_fail++; $display("FAIL rand_alu_ready[%0d]: got %0b want %0b", c, alu_ready, exp_ar);
                end
            end
            if (m.valid) begin
                n_checks++; if (mem_ready !== exp_mr) begin
                    n_fail++; $display("FAIL rand_mem_ready[%0d]: got %0b want %0b", c, mem_ready, exp_mr);
                end
            end
            if (mem_wins) begin
                exp_we = 1'b1; exp_ad = m.rd; exp_wd = m.data;
            end else if (alu_wins) begin
                exp_we = 1'b1; exp_ad = a.rd; exp_wd = a.data;
            end else begin
                exp_we = 1'b0;
            end
            if (!m.valid || mem_wins) begin
                m_starve = 0;
                m_boost  = 1'b0;
            end else if (m_req) begin
                m_starve++;
                if (m_starve >= LIMIT) m_boost = 1'b1;
            end
            if (a.valid && exp_ar) a.valid = 1'b0;
            if (m.valid && exp_mr) m.valid = 1'b0;
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (WE3 !== exp_we || ad3 !== exp_ad || WD3 !== exp_wd) begin
            n_fail++; $display("FAIL rand_last: got %0b/%0d/%0h want %0b/%0d/%0h", WE3, ad3, WD3, exp_we, exp_ad, exp_wd);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        test_reset;
        test_single_alu;
        test_contention;
        test_x0;
        test_same_rd;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
